// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Purpose : shared constants for the bitwise logic unit family.
//   OPW          - opcode width (fixed 3-bit encoding)
//   OP_NOT..OP_PASS - opcode encodings consumed by logic_op_comb
package logic_unit_pkg;

   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_NOT  = 3'b000;
   localparam logic [OPW-1:0] OP_AND  = 3'b001;
   localparam logic [OPW-1:0] OP_OR   = 3'b010;
   localparam logic [OPW-1:0] OP_XOR  = 3'b011;
   localparam logic [OPW-1:0] OP_NAND = 3'b100;
   localparam logic [OPW-1:0] OP_NOR  = 3'b101;
   localparam logic [OPW-1:0] OP_XNOR = 3'b110;
   localparam logic [OPW-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_comb.sv
// logic_op_comb
// Purpose : purely combinational per-bit logic operator, reusable by any
//           datapath block that needs the eight-op gate set.
// Ports   :
//   op [OPW-1:0]   opcode (logic_unit_pkg encoding)
//   a  [WIDTH-1:0] operand A (sole operand for NOT / PASS)
//   b  [WIDTH-1:0] operand B (ignored for NOT / PASS)
//   f  [WIDTH-1:0] result
module logic_op_comb
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f
);

   always_comb begin
      f = a;
      case (op)
         OP_NOT:  f = ~a;
         OP_AND:  f = a & b;
         OP_OR:   f = a | b;
         OP_XOR:  f = a ^ b;
         OP_NAND: f = ~(a & b);
         OP_NOR:  f = ~(a | b);
         OP_XNOR: f = ~(a ^ b);
         OP_PASS: f = a;
         default: f = a;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Purpose : two-stage pipelined bitwise logic unit with valid/ready
//           handshake, an accumulator that can replace operand A, and a
//           zero flag on the result.
// Optional: define LOGIC_PARITY_EN to add the out_parity port and its
//           stage-2 register (XOR-reduce of the result).
// Ports   :
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   request handshake
//   in_a, in_b, in_op     operands and opcode
//   in_acc_sel            accumulator replaces operand A
//   acc_clr               clear accumulator (op sees 0 if accepted same cycle)
//   out_valid / out_ready result handshake
//   out_f, out_zero       result and result==0 flag (stage-2 registers)
//   acc_q                 current accumulator value
//   out_parity            XOR-reduce of result (LOGIC_PARITY_EN only)
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OPW-1:0]   in_op,
   input  logic             in_acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_zero,
   output logic [WIDTH-1:0] acc_q
`ifdef LOGIC_PARITY_EN
   ,
   output logic             out_parity
`endif
);

   logic             adv1, adv2, accept;
   logic [WIDTH-1:0] acc_eff, opa, res;
   logic             vld_p1, vld_p2;
   logic [WIDTH-1:0] f_p1, f_p2;
   logic             zero_p2;

   // A stage may load whenever it is empty or its contents move on this edge.
   assign adv2     = !vld_p2 || out_ready;
   assign adv1     = !vld_p1 || adv2;
   assign in_ready = adv1;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle as an accumulator op makes the op see zero.
   assign acc_eff = acc_clr ? '0 : acc_q;
   assign opa     = in_acc_sel ? acc_eff : in_a;

   logic_op_comb #(.WIDTH(WIDTH)) u_op (
      .op (in_op),
      .a  (opa),
      .b  (in_b),
      .f  (res)
   );

   // Accumulator updates at accept, so back-to-back acc ops never stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= res;
      end else if (acc_clr) begin
         acc_q <= '0;
      end
   end

   // ---- stage 1: capture operator result ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         f_p1   <= '0;
      end else if (adv1) begin
         vld_p1 <= accept;
         if (accept) f_p1 <= res;
      end
   end

   // ---- stage 2: output registers and flags ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         f_p2    <= '0;
         zero_p2 <= 1'b0;
      end else if (adv2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            f_p2    <= f_p1;
            zero_p2 <= ~|f_p1;
         end
      end
   end

`ifdef LOGIC_PARITY_EN
   logic par_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_p2 <= 1'b0;
      end else if (adv2 && vld_p1) begin
         par_p2 <= ^f_p1;
      end
   end

   assign out_parity = par_p2;
`endif

   assign out_valid = vld_p2;
   assign out_f     = f_p2;
   assign out_zero  = zero_p2;

endmodule
